bitstream_serializer: RTL and testbench

- Parallel-in/serial-out stage that sits directly upstream of the overlapping Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `bitstream`, which drives the detector's serial input.
- A one-word holding register lets consecutive words stream with no idle gap between them.
- Between words the line parks at IDLE_BIT, chosen so the detector does not see spurious pattern bits.

---
 rtl/bitstream_serializer.sv | 126 ++++++++++++
 tb/tb_bitstream_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bitstream_serializer.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// A one-word hold register lets consecutive words stream without an idle gap.
module bitstream_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bitstream,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic [WIDTH-1:0] hold_r, hold_s;
    logic             hold_full_r, hold_full_s;
    logic [CW-1:0]    cnt_r, cnt_s;

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {w[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, w[WIDTH-1:1]};
        end
        return r;
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        logic b;
        if (MSB_FIRST) begin
            b = w[WIDTH-1];
        end else begin
            b = w[0];
        end
        return b;
    endfunction

    // Next-state logic: shifter, word counter, hold register and handshake.
    always_comb begin
        state_s     = state_r;
        sreg_s      = sreg_r;
        cnt_s       = cnt_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        case (state_r)
            IDLE: begin
                if (hold_full_r) begin
                    sreg_s      = hold_r;
                    hold_full_s = 1'b0;
                    cnt_s       = '0;
                    state_s     = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r != LAST) begin
                    sreg_s = shift_word(sreg_r);
                    cnt_s  = cnt_r + 1'b1;
                end else if (hold_full_r) begin
                    // Next word follows the last bit with no gap.
                    sreg_s      = hold_r;
                    hold_full_s = 1'b0;
                    cnt_s       = '0;
                end else begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
        // hold is only consumed while full, so a refill never collides with a read.
        if (din_valid && !hold_full_r) begin
            hold_s      = din;
            hold_full_s = 1'b1;
        end else begin
            hold_s = hold_s;
        end
    end

    // State registers; outputs are registered from the next-state values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            sreg_r      <= '0;
            cnt_r       <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            din_ready   <= 1'b1;
            bit_valid   <= 1'b0;
            bitstream   <= IDLE_BIT;
            word_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            sreg_r      <= sreg_s;
            cnt_r       <= cnt_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            din_ready   <= !hold_full_s;
            bit_valid   <= (state_s == SHIFT);
            bitstream   <= (state_s == SHIFT) ? out_bit(sreg_s) : IDLE_BIT;
            word_done   <= (state_s == SHIFT) && (cnt_s == LAST);
            busy        <= (state_s == SHIFT) || hold_full_s;
        end
    end

endmodule

// File: tb/tb_bitstream_serializer.sv
// Directed bench for bitstream_serializer: an MSB-first and an LSB-first instance.
module tb_bitstream_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] din_m, din_l;
    logic       dv_m, dv_l;
    logic       rdy_m, rdy_l;
    logic       bs_m, bs_l;
    logic       bv_m, bv_l;
    logic       wd_m, wd_l;
    logic       busy_m, busy_l;

    int n_cmp = 0;
    int n_err = 0;

    bitstream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
        .clk(clk), .reset(reset), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
        .bitstream(bs_m), .bit_valid(bv_m), .word_done(wd_m), .busy(busy_m)
    );

    bitstream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
        .bitstream(bs_l), .bit_valid(bv_l), .word_done(wd_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a word from a negedge and return at the negedge after it is taken.
    task automatic push(input bit lsb, input logic [7:0] w);
        int t;
        t = 0;
        if (lsb) begin din_l = w; dv_l = 1'b1; end
        else     begin din_m = w; dv_m = 1'b1; end
        while (!(lsb ? rdy_l : rdy_m) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", lsb ? rdy_l : rdy_m, 1'b1);
        @(negedge clk);
        if (lsb) dv_l = 1'b0;
        else     dv_m = 1'b0;
    endtask

    // Expect n contiguous data bits, first-emitted bit in bits[n-1], then idle.
    task automatic expect_stream(input string tag, input bit lsb,
                                 input logic [31:0] bits, input int n);
        int t;
        t = 0;
        while (!(lsb ? bv_l : bv_m) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_start"}, lsb ? bv_l : bv_m, 1'b1);
        if (!(lsb ? bv_l : bv_m)) return;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_bit"},   lsb ? bs_l : bs_m, bits[n-1-i]);
            chk({tag, "_valid"}, lsb ? bv_l : bv_m, 1'b1);
            chk({tag, "_done"},  lsb ? wd_l : wd_m, (i % 8) == 7);
            chk({tag, "_busy"},  lsb ? busy_l : busy_m, 1'b1);
            @(negedge clk);
        end
        chk({tag, "_end_valid"}, lsb ? bv_l : bv_m, 1'b0);
        chk({tag, "_end_idle"},  lsb ? bs_l : bs_m, 1'b1);
        chk({tag, "_end_done"},  lsb ? wd_l : wd_m, 1'b0);
        chk({tag, "_end_busy"},  lsb ? busy_l : busy_m, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_bv;
        reset = 1'b0;
        din_m = 8'h00; din_l = 8'h00;
        dv_m  = 1'b0;  dv_l  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", rdy_m, 1'b1);
        chk("rst_valid", bv_m, 1'b0);
        chk("rst_bit",   bs_m, 1'b1);
        chk("rst_busy",  busy_m, 1'b0);
        chk("rst_done",  wd_m, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", bv_m, 1'b0);
            chk("post_rst_bit",   bs_m, 1'b1);
            chk("post_rst_ready", rdy_m, 1'b1);
        end

        // Single word, MSB first.
        fork
            push(1'b0, 8'h36);
            expect_stream("single", 1'b0, 32'h0000_0036, 8);
        join

        // Back-to-back words with no gap.
        @(negedge clk);
        fork
            begin
                push(1'b0, 8'hA5);
                push(1'b0, 8'h3C);
            end
            expect_stream("b2b", 1'b0, 32'h0000_A53C, 16);
            begin
                @(negedge clk);
                chk("b2b_ready_drop", rdy_m, 1'b0);
            end
        join

        // LSB-first instance.
        @(negedge clk);
        fork
            push(1'b1, 8'h01);
            expect_stream("lsb01", 1'b1, 32'h0000_0080, 8);
        join
        @(negedge clk);
        fork
            push(1'b1, 8'hB2);
            expect_stream("lsbB2", 1'b1, 32'h0000_004D, 8);
        join

        // Backpressure: candidate changes while din_ready is low.
        @(negedge clk);
        fork
            begin
                int t;
                push(1'b0, 8'hC3);
                push(1'b0, 8'h96);
                dv_m = 1'b1;
                t = 0;
                while (!rdy_m && t < 40) begin
                    din_m = 8'h80 + 8'(t);
                    @(negedge clk);
                    t++;
                end
                din_m = 8'h5A;
                @(negedge clk);
                dv_m = 1'b0;
            end
            expect_stream("bp", 1'b0, 32'h00C3_965A, 24);
        join

        // Reset mid-word discards both the shifting and the held word.
        @(negedge clk);
        push(1'b0, 8'hF0);
        push(1'b0, 8'h0F);
        chk("mid_valid_pre", bv_m, 1'b1);
        chk("mid_bit_pre",   bs_m, 1'b1);
        @(negedge clk);
        chk("mid_bit3_pre",  bs_m, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bv_m, 1'b0);
        chk("mid_rst_bit",   bs_m, 1'b1);
        chk("mid_rst_busy",  busy_m, 1'b0);
        chk("mid_rst_ready", rdy_m, 1'b1);
        chk("mid_rst_done",  wd_m, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cnt_bv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bv_m) cnt_bv++;
        end
        chk("mid_no_emit", cnt_bv, 0);
        chk("mid_end_busy", busy_m, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
